// File: rtl/bc_defs.sv
// Shared constants for the basic-computer control path: bus sources, ALU ops,
// memory-reference opcodes and the execute-sequencer state encoding.
package bc_defs;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_PC   = 3'b001;
  localparam logic [2:0] BUS_AR   = 3'b010;
  localparam logic [2:0] BUS_DR   = 3'b011;
  localparam logic [2:0] BUS_IR   = 3'b100;
  localparam logic [2:0] BUS_AC   = 3'b101;
  localparam logic [2:0] BUS_MEM  = 3'b110;
  localparam logic [2:0] BUS_TR   = 3'b111;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_LDR  = 3'b010;
  localparam logic [2:0] ALU_NONE = 3'b111;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_LDA = 3'b010,
    OP_STA = 3'b011,
    OP_BUN = 3'b100,
    OP_BSA = 3'b101,
    OP_ISZ = 3'b110,
    OP_NON_MRI = 3'b111
  } mri_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IND,
    S_EX1,
    S_EX2,
    S_EX3
  } mri_state_t;

endpackage

// File: rtl/mem_ref_sequencer.sv
// Execute-phase sequencer for memory-reference instructions: one optional
// indirect cycle, then up to three micro-op cycles decoded Moore-style.
module mem_ref_sequencer
  import bc_defs::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       i_bit,
  input  logic       dr_zero,
  output logic       busy,
  output logic       done,
  output logic [2:0] bus_sel,
  output logic       ld_ar,
  output logic       inr_ar,
  output logic       ld_pc,
  output logic       inr_pc,
  output logic       ld_dr,
  output logic       inr_dr,
  output logic       ld_ac,
  output logic [2:0] alu_sel,
  output logic       mem_we
);

  if (WIDTH < 12) begin : g_width_check
    $error("WIDTH must be wide enough to carry a 12-bit address");
  end

  mri_state_t state, state_nxt;
  mri_op_t    op_q;
  logic       accept;

  assign accept = (state == S_IDLE) && start && (mri_op_t'(opcode) != OP_NON_MRI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= OP_AND;
    end else begin
      state <= state_nxt;
      if (accept) op_q <= mri_op_t'(opcode);
    end
  end

  // i_bit only steers the IDLE exit, so it is consumed at accept time
  // rather than held in a separate register.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    bus_sel   = BUS_NONE;
    alu_sel   = ALU_NONE;
    ld_ar     = 1'b0;
    inr_ar    = 1'b0;
    ld_pc     = 1'b0;
    inr_pc    = 1'b0;
    ld_dr     = 1'b0;
    inr_dr    = 1'b0;
    ld_ac     = 1'b0;
    mem_we    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = i_bit ? S_IND : S_EX1;
      end

      S_IND: begin
        bus_sel   = BUS_MEM;
        ld_ar     = 1'b1;
        state_nxt = S_EX1;
      end

      S_EX1: begin
        unique case (op_q)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            bus_sel   = BUS_MEM;
            ld_dr     = 1'b1;
            state_nxt = S_EX2;
          end
          OP_STA: begin
            bus_sel   = BUS_AC;
            mem_we    = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
          OP_BUN: begin
            bus_sel   = BUS_AR;
            ld_pc     = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
          OP_BSA: begin
            bus_sel   = BUS_PC;
            mem_we    = 1'b1;
            inr_ar    = 1'b1;
            state_nxt = S_EX2;
          end
          default: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        endcase
      end

      S_EX2: begin
        unique case (op_q)
          OP_AND: begin
            alu_sel   = ALU_AND;
            ld_ac     = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
          OP_ADD: begin
            alu_sel   = ALU_ADD;
            ld_ac     = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
          OP_LDA: begin
            alu_sel   = ALU_LDR;
            ld_ac     = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
          OP_BSA: begin
            bus_sel   = BUS_AR;
            ld_pc     = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
          OP_ISZ: begin
            inr_dr    = 1'b1;
            state_nxt = S_EX3;
          end
          default: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        endcase
      end

      S_EX3: begin
        bus_sel   = BUS_DR;
        mem_we    = 1'b1;
        inr_pc    = dr_zero;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ref_sequencer.sv
// Bench for mem_ref_sequencer: a register/memory datapath obeys the DUT strobes,
// and results are compared with instruction-level semantics of each opcode.
module tb_mem_ref_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, i_bit, dr_zero;
  logic [2:0] opcode;
  logic       busy, done, ld_ar, inr_ar, ld_pc, inr_pc, ld_dr, inr_dr, ld_ac, mem_we;
  logic [2:0] bus_sel, alu_sel;

  int n_assert = 0;
  int n_fail   = 0;

  mem_ref_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .i_bit(i_bit),
    .dr_zero(dr_zero), .busy(busy), .done(done), .bus_sel(bus_sel),
    .ld_ar(ld_ar), .inr_ar(inr_ar), .ld_pc(ld_pc), .inr_pc(inr_pc),
    .ld_dr(ld_dr), .inr_dr(inr_dr), .ld_ac(ld_ac), .alu_sel(alu_sel),
    .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  // Datapath model: architectural registers plus memory, updated by the strobes
  logic [11:0] ar, pc;
  logic [15:0] dr, ac;
  logic        e;
  logic [15:0] mem [0:4095];
  logic [15:0] bus_v;
  int          we_cnt = 0;

  logic        pk_mem = 1'b0, pk_regs = 1'b0;
  logic [11:0] pk_addr, pk_ar, pk_pc;
  logic [15:0] pk_data, pk_ac;
  logic        pk_e;

  assign dr_zero = (dr == 16'h0000);

  always_comb begin
    case (bus_sel)
      3'b001:  bus_v = {4'h0, pc};
      3'b010:  bus_v = {4'h0, ar};
      3'b011:  bus_v = dr;
      3'b101:  bus_v = ac;
      3'b110:  bus_v = mem[ar];
      default: bus_v = 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    if (pk_mem) begin
      mem[pk_addr] <= pk_data;
    end else if (pk_regs) begin
      ar <= pk_ar; pc <= pk_pc; ac <= pk_ac; e <= pk_e; dr <= 16'h0000;
    end else begin
      if (ld_ar) ar <= bus_v[11:0]; else if (inr_ar) ar <= ar + 12'd1;
      if (ld_pc) pc <= bus_v[11:0]; else if (inr_pc) pc <= pc + 12'd1;
      if (ld_dr) dr <= bus_v;       else if (inr_dr) dr <= dr + 16'd1;
      if (ld_ac) begin
        case (alu_sel)
          3'b000:  ac <= ac & dr;
          3'b001:  {e, ac} <= {1'b0, ac} + {1'b0, dr};
          3'b010:  ac <= dr;
          default: ac <= ac;
        endcase
      end
      if (mem_we) begin
        mem[ar] <= bus_v;
        we_cnt  <= we_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke_mem(input logic [11:0] a, input logic [15:0] d);
    pk_mem = 1'b1; pk_addr = a; pk_data = d;
    @(negedge clk);
    pk_mem = 1'b0;
  endtask

  task automatic poke_regs(input logic [11:0] a, input logic [11:0] p,
                           input logic [15:0] acc, input logic ee);
    pk_regs = 1'b1; pk_ar = a; pk_pc = p; pk_ac = acc; pk_e = ee;
    @(negedge clk);
    pk_regs = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bus"}, bus_sel, 3'b000);
    check({tag, "_alu"}, alu_sel, 3'b111);
    check({tag, "_stb"}, {ld_ar, inr_ar, ld_pc, inr_pc, ld_dr, inr_dr, ld_ac, mem_we}, 8'h00);
  endtask

  // Per-cycle log of the last run, indexed by cycles after the start edge
  logic [2:0] log_bus [1:8];
  logic [2:0] log_alu [1:8];
  logic [7:0] log_stb [1:8];
  logic       log_done [1:8];

  // Issues one instruction from the current machine state and checks the
  // architectural outcome against the opcode's semantics.
  task automatic exec_check(input logic [2:0] op, input logic ib, input logic restart,
                            input string tag);
    logic [11:0] a0, pc0, ea, exp_ar, exp_pc;
    logic [15:0] ac0, m_ea, m_a0, exp_ac, exp_m;
    logic        e0, exp_e;
    int          lat, we0, exp_we, first_done, ndone, nbusy;
    int          base_lat [0:6];
    base_lat = '{2, 2, 2, 1, 1, 2, 3};

    a0 = ar; pc0 = pc; ac0 = ac; e0 = e; we0 = we_cnt;
    m_a0 = mem[a0];
    ea   = ib ? m_a0[11:0] : a0;
    m_ea = mem[ea];

    exp_ac = ac0; exp_e = e0; exp_pc = pc0; exp_m = m_ea; exp_ar = ea; exp_we = 0;
    case (op)
      3'b000: exp_ac = ac0 & m_ea;
      3'b001: {exp_e, exp_ac} = {1'b0, ac0} + {1'b0, m_ea};
      3'b010: exp_ac = m_ea;
      3'b011: begin exp_m = ac0; exp_we = 1; end
      3'b100: exp_pc = ea;
      3'b101: begin exp_m = {4'h0, pc0}; exp_pc = ea + 12'd1; exp_ar = ea + 12'd1; exp_we = 1; end
      default: begin
        exp_m = m_ea + 16'd1; exp_we = 1;
        if (exp_m == 16'h0000) exp_pc = pc0 + 12'd1;
      end
    endcase
    lat = base_lat[op] + (ib ? 1 : 0);

    start = 1'b1; opcode = op; i_bit = ib;
    @(negedge clk);
    start = 1'b0;
    opcode = 3'($urandom_range(0, 6));
    i_bit  = 1'($urandom);
    first_done = 0; ndone = 0; nbusy = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1 && restart) start = 1'b1;
      if (c == 2) start = 1'b0;
      log_bus[c]  = bus_sel;
      log_alu[c]  = alu_sel;
      log_stb[c]  = {ld_ar, inr_ar, ld_pc, inr_pc, ld_dr, inr_dr, ld_ac, mem_we};
      log_done[c] = done;
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
      check({tag, "_pc_excl"}, {31'd0, ld_pc & inr_pc}, 0);
      @(negedge clk);
    end

    check({tag, "_latency"}, first_done, lat);
    check({tag, "_busy_cycles"}, nbusy, lat);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_ac"}, ac, exp_ac);
    check({tag, "_e"}, e, exp_e);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_ar"}, ar, exp_ar);
    check({tag, "_mem_ea"}, mem[ea], exp_m);
    check({tag, "_we_count"}, we_cnt - we0, exp_we);
    if (ib && ea != a0) check({tag, "_mem_ptr"}, mem[a0], m_a0);
  endtask

  initial begin
    logic [11:0] ra, rp;
    logic [15:0] rv;
    int we_snap;

    rst = 1'b1; start = 1'b0; opcode = 3'b000; i_bit = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // LDA direct
    poke_regs(12'h050, 12'h000, 16'hAAAA, 1'b0);
    poke_mem(12'h050, 16'h1234);
    exec_check(3'b010, 1'b0, 1'b0, "lda");
    check("lda_c1_bus", log_bus[1], 3'b110);
    check("lda_c1_lddr", log_stb[1][3], 1);
    check("lda_c2_alu", log_alu[2], 3'b010);
    check("lda_c2_ldac", log_stb[2][1], 1);
    check("lda_c2_done", log_done[2], 1);
    check("lda_ac_const", ac, 16'h1234);

    // ADD indirect
    poke_regs(12'h010, 12'h000, 16'h0003, 1'b0);
    poke_mem(12'h010, 16'h0020);
    poke_mem(12'h020, 16'h0005);
    exec_check(3'b001, 1'b1, 1'b0, "add_ind");
    check("add_ind_c1_ldar", {log_bus[1], log_stb[1][7]}, {3'b110, 1'b1});
    check("add_ind_ar_const", ar, 12'h020);
    check("add_ind_ac_const", ac, 16'h0008);

    // BSA
    poke_regs(12'h100, 12'h021, 16'h0000, 1'b0);
    poke_mem(12'h100, 16'h5555);
    exec_check(3'b101, 1'b0, 1'b0, "bsa");
    check("bsa_mem_const", mem[12'h100], 16'h0021);
    check("bsa_pc_const", pc, 12'h101);

    // ISZ wrap-and-skip, then no-skip; second start during the wrap case
    poke_regs(12'h200, 12'h300, 16'h0000, 1'b0);
    poke_mem(12'h200, 16'hFFFF);
    exec_check(3'b110, 1'b0, 1'b1, "isz_skip");
    check("isz_skip_mem_const", mem[12'h200], 16'h0000);
    check("isz_skip_c3_inrpc", log_stb[3][4], 1);
    poke_regs(12'h200, 12'h300, 16'h0000, 1'b0);
    poke_mem(12'h200, 16'h0007);
    exec_check(3'b110, 1'b0, 1'b0, "isz_noskip");
    check("isz_noskip_mem_const", mem[12'h200], 16'h0008);
    check("isz_noskip_c3_inrpc", log_stb[3][4], 0);

    // Non-memory-reference opcode is ignored
    we_snap = we_cnt;
    start = 1'b1; opcode = 3'b111; i_bit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_idle_outputs("op111");
      @(negedge clk);
    end
    check("op111_we", we_cnt - we_snap, 0);

    // Reset during ISZ EX2
    poke_regs(12'h200, 12'h300, 16'h0000, 1'b0);
    poke_mem(12'h200, 16'hFFFF);
    we_snap = we_cnt;
    start = 1'b1; opcode = 3'b110; i_bit = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_mid_ex2_inrdr", inr_dr, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    repeat (4) begin
      check_idle_outputs("rst_after");
      @(negedge clk);
    end
    check("rst_mid_we", we_cnt - we_snap, 0);

    // Randomized instructions
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      logic       ib;
      op = 3'($urandom_range(0, 6));
      ib = 1'($urandom);
      ra = 12'($urandom);
      do rp = 12'($urandom); while (rp == ra);
      rv = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
      poke_regs(ra, 12'($urandom), 16'($urandom), 1'($urandom));
      poke_mem(ra, ib ? {4'($urandom), rp} : rv);
      if (ib) poke_mem(rp, rv);
      exec_check(op, ib, 1'($urandom), $sformatf("rnd%0d_op%0d_i%0d", n, op, ib));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
